// File: rtl/register_file_fwd.sv
// 128 x 128-bit SPU register file with three registered read ports and two write-back ports.
// Same-cycle write-back data is forwarded into the reads, with the odd pipe taking precedence.
module register_file_fwd #(
    parameter int NUM_REGS = 128,
    parameter int WIDTH    = 128,
    parameter int ADDR_W   = 7
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic [0:ADDR_W-1] i_ra_addr,
    input  logic [0:ADDR_W-1] i_rb_addr,
    input  logic [0:ADDR_W-1] i_rc_addr,
    input  logic [0:WIDTH-1]  i_rt_wb_even,
    input  logic [0:ADDR_W-1] i_rt_addr_wb_even,
    input  logic              i_reg_write_wb_even,
    input  logic [0:WIDTH-1]  i_rt_wb_odd,
    input  logic [0:ADDR_W-1] i_rt_addr_wb_odd,
    input  logic              i_reg_write_wb_odd,
    output logic [0:WIDTH-1]  o_ra,
    output logic [0:WIDTH-1]  o_rb,
    output logic [0:WIDTH-1]  o_rc,
    output logic              o_wr_conflict
);

    localparam int NUM_PORTS = 3;

    logic [0:WIDTH-1]  r_regs     [0:NUM_REGS-1];
    logic [0:ADDR_W-1] r_addr_q   [0:NUM_PORTS-1];
    logic [0:WIDTH-1]  r_rd       [0:NUM_PORTS-1];
    logic              r_wr_conflict;

    logic [0:ADDR_W-1] w_addr_in  [0:NUM_PORTS-1];
    logic [0:ADDR_W-1] w_sel      [0:NUM_PORTS-1];
    logic [0:WIDTH-1]  w_byp      [0:NUM_PORTS-1];
    logic              w_same_addr_write;

    assign w_addr_in[0] = i_ra_addr;
    assign w_addr_in[1] = i_rb_addr;
    assign w_addr_in[2] = i_rc_addr;

    assign w_same_addr_write = i_reg_write_wb_even && i_reg_write_wb_odd &&
                               (i_rt_addr_wb_even == i_rt_addr_wb_odd);

    // Odd pipe is assigned last so it wins a same-address double write.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (i_reg_write_wb_even) begin
                r_regs[i_rt_addr_wb_even] <= i_rt_wb_even;
            end
            if (i_reg_write_wb_odd) begin
                r_regs[i_rt_addr_wb_odd] <= i_rt_wb_odd;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr_conflict <= 1'b0;
        end else if (w_same_addr_write) begin
            r_wr_conflict <= 1'b1;
        end
    end

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_read_port
            assign w_sel[p] = i_stall ? r_addr_q[p] : w_addr_in[p];

            always_comb begin
                w_byp[p] = r_regs[w_sel[p]];
                if (i_reg_write_wb_odd && (i_rt_addr_wb_odd == w_sel[p])) begin
                    w_byp[p] = i_rt_wb_odd;
                end else if (i_reg_write_wb_even && (i_rt_addr_wb_even == w_sel[p])) begin
                    w_byp[p] = i_rt_wb_even;
                end
            end

            // Held addresses are re-read every stalled cycle so write-backs stay visible.
            always_ff @(posedge i_clk) begin
                if (!i_reset) begin
                    r_addr_q[p] <= '0;
                    r_rd[p]     <= '0;
                end else begin
                    if (!i_stall) begin
                        r_addr_q[p] <= w_addr_in[p];
                    end
                    r_rd[p] <= w_byp[p];
                end
            end
        end
    endgenerate

    assign o_ra          = r_rd[0];
    assign o_rb          = r_rd[1];
    assign o_rc          = r_rd[2];
    assign o_wr_conflict = r_wr_conflict;

endmodule
